// File: rtl/font_arb_pkg.sv
// Shared definitions for the font ROM arbiter: requester indices, default widths and
// the glyph address packing helper.
package font_arb_pkg;

    localparam int unsigned REQ_HORA  = 0;
    localparam int unsigned REQ_FECHA = 1;
    localparam int unsigned REQ_TIMER = 2;
    localparam int unsigned REQ_RING  = 3;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_ADDR_W  = 11;
    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_ROM_LAT = 1;

    typedef enum logic [1:0] {
        ReqHora  = 2'd0,
        ReqFecha = 2'd1,
        ReqTimer = 2'd2,
        ReqRing  = 2'd3
    } req_id_e;

    // ROM address layout is {char_code, row}
    function automatic logic [10:0] glyph_addr(input logic [6:0] char_code,
                                               input logic [3:0] row);
        return {char_code, row};
    endfunction

endpackage

// File: rtl/font_rom_arbiter_if.sv
// Requester/ROM bus of the font ROM arbiter; slave is the arbiter side, master is the
// requesters plus ROM side.
interface font_rom_arbiter_if
    import font_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W
) ();

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic                      alarma_on;
    logic [NUM_REQ-1:0]        gnt;
    logic                      rom_en;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DATA_W-1:0]         rom_data;
    logic [DATA_W-1:0]         rdata;
    logic [NUM_REQ-1:0]        rvalid;

    modport slave (
        input  req, addr, alarma_on, rom_data,
        output gnt, rom_en, rom_addr, rdata, rvalid
    );

    modport master (
        output req, addr, alarma_on, rom_data,
        input  gnt, rom_en, rom_addr, rdata, rvalid
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index after i_last, wrapping N-1 -> 0.
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_elig,
    input  logic [IDX_W-1:0] i_last,
    output logic [N-1:0]     o_win,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin
        int j;
        j       = 0;
        o_win   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        // Walk from farthest to nearest so the nearest eligible index overwrites last
        for (int k = int'(N); k > 0; k--) begin
            j = (int'(i_last) + k) % int'(N);
            if (i_elig[j]) begin
                o_win    = '0;
                o_win[j] = 1'b1;
                o_idx    = IDX_W'(j);
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/font_rom_arbiter.sv
// Shares one synchronous font ROM between the VGA text generators with round-robin grants
// and a tagged return path. FONT_ARB_ALARM_PRIO_EN gives the ring requester priority.
module font_rom_arbiter
    import font_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ROM_LAT = DEF_ROM_LAT
) (
    input logic               clk,
    input logic               reset,
    font_rom_arbiter_if.slave bus
);

    localparam int unsigned     IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0] r_gnt;
    logic               r_rom_en;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic [IDX_W-1:0]   r_last;
    logic [NUM_REQ-1:0] r_tag [ROM_LAT];
    logic [NUM_REQ-1:0] r_rvalid;
    logic [DATA_W-1:0]  r_rdata;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_rr_win;
    logic [IDX_W-1:0]   w_rr_idx;
    logic               w_rr_valid;
    logic               w_prio;
    logic [NUM_REQ-1:0] w_win;
    logic               w_fire;
    logic [ADDR_W-1:0]  w_addr;

    // Last cycle's winner still holds req while it sees gnt, so mask it out
    assign w_elig = bus.req & ~r_gnt;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_elig  (w_elig),
        .i_last  (r_last),
        .o_win   (w_rr_win),
        .o_idx   (w_rr_idx),
        .o_valid (w_rr_valid)
    );

`ifdef FONT_ARB_ALARM_PRIO_EN
    assign w_prio = bus.alarma_on & w_elig[NUM_REQ-1];
`else
    logic w_unused_alarm;
    assign w_unused_alarm = bus.alarma_on;
    assign w_prio         = 1'b0;
`endif

    always_comb begin
        w_win  = w_rr_win;
        w_fire = w_rr_valid;
        if (w_prio) begin
            w_win          = '0;
            w_win[NUM_REQ-1] = 1'b1;
            w_fire         = 1'b1;
        end
        w_addr = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_win[i]) begin
                w_addr = bus.addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt      <= '0;
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
            r_last     <= LAST_RST;
            r_rvalid   <= '0;
            r_rdata    <= '0;
            for (int i = 0; i < int'(ROM_LAT); i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_gnt    <= w_win;
            r_rom_en <= w_fire;
            if (w_fire) begin
                r_rom_addr <= w_addr;
            end
            // Priority grants to ring leave the rotation where it was
            if (w_rr_valid && !w_prio) begin
                r_last <= w_rr_idx;
            end
            r_tag[0] <= r_gnt;
            for (int i = 1; i < int'(ROM_LAT); i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            r_rvalid <= r_tag[ROM_LAT-1];
            if (|r_tag[ROM_LAT-1]) begin
                r_rdata <= bus.rom_data;
            end
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.rom_en   = r_rom_en;
    assign bus.rom_addr = r_rom_addr;
    assign bus.rvalid   = r_rvalid;
    assign bus.rdata    = r_rdata;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Self-checking bench for font_rom_arbiter: directed scenarios plus random requesters,
// checked every cycle against a transaction-level reference model.
module tb_font_rom_arbiter;
    import font_arb_pkg::*;

    localparam int unsigned N  = DEF_NUM_REQ;
    localparam int unsigned AW = DEF_ADDR_W;
    localparam int unsigned DW = DEF_DATA_W;
    localparam int          NI = int'(N);

    logic clk   = 1'b0;
    logic reset = 1'b0;

    font_rom_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    font_rom_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .ROM_LAT (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        logic [AW-1:0] t;
        t = a * 11'd37 + 11'h02B;
        return t[7:0] ^ a[10:3];
    endfunction

    // Synchronous ROM with one cycle of latency
    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_data <= rom_f(bus.rom_addr);
    end

    // Requester-side stimulus state
    logic [N-1:0]  t_req;
    logic [AW-1:0] t_addr [N];
    logic          t_alarm;

    // Reference model state
    int            m_last;
    logic [N-1:0]  m_gnt;
    logic          m_rom_en;
    logic [AW-1:0] m_rom_addr;
    logic [DW-1:0] m_rdata;
    logic [N-1:0]  p1_v, p2_v;
    logic [DW-1:0] p1_d, p2_d;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.req       = t_req;
        bus.alarma_on = t_alarm;
        for (int i = 0; i < NI; i++) bus.addr[i*AW +: AW] = t_addr[i];
    endtask

    task automatic model_reset();
        m_last     = NI - 1;
        m_gnt      = '0;
        m_rom_en   = 1'b0;
        m_rom_addr = '0;
        m_rdata    = '0;
        p1_v = '0; p2_v = '0; p1_d = '0; p2_d = '0;
    endtask

    // One clock cycle: predict the winner from the current requests, clock, then compare
    task automatic step();
        logic [N-1:0] elig;
        logic [N-1:0] rv;
        int           w;
        bit           prio;
        drive();
        elig = t_req & ~m_gnt;
        w    = -1;
        prio = 1'b0;
`ifdef FONT_ARB_ALARM_PRIO_EN
        if (t_alarm && elig[N-1]) begin
            w    = NI - 1;
            prio = 1'b1;
        end
`endif
        if (w < 0) begin
            for (int k = 1; k <= NI; k++) begin
                int j;
                j = (m_last + k) % NI;
                if (elig[j] && w < 0) w = j;
            end
        end
        @(posedge clk);
        #1;
        rv = p2_v;
        if (rv != '0) m_rdata = p2_d;
        p2_v = p1_v;
        p2_d = p1_d;
        m_gnt = '0;
        if (w >= 0) begin
            m_gnt[w]   = 1'b1;
            m_rom_en   = 1'b1;
            m_rom_addr = t_addr[w];
            if (!prio) m_last = w;
            p1_v = m_gnt;
            p1_d = rom_f(t_addr[w]);
        end else begin
            m_rom_en = 1'b0;
            p1_v     = '0;
        end
        chk("gnt",      32'(bus.gnt),      32'(m_gnt));
        chk("rom_en",   32'(bus.rom_en),   32'(m_rom_en));
        chk("rom_addr", 32'(bus.rom_addr), 32'(m_rom_addr));
        chk("rvalid",   32'(bus.rvalid),   32'(rv));
        chk("rdata",    32'(bus.rdata),    32'(m_rdata));
    endtask

    // Granted requesters either re-request with a new address (keep) or drop
    task automatic run(input int n, input bit keep);
        repeat (n) begin
            step();
            for (int i = 0; i < NI; i++) begin
                if (m_gnt[i]) begin
                    t_req[i]  = keep;
                    t_addr[i] = AW'($urandom);
                end
            end
        end
    endtask

    task automatic run_rand(input int n);
        repeat (n) begin
            step();
            for (int i = 0; i < NI; i++) begin
                if (m_gnt[i]) begin
                    t_req[i]  = 1'($urandom_range(1, 0));
                    t_addr[i] = AW'($urandom);
                end else if (!t_req[i]) begin
                    if ($urandom_range(2, 0) == 0) begin
                        t_req[i]  = 1'b1;
                        t_addr[i] = AW'($urandom);
                    end
                end else if ($urandom_range(15, 0) == 0) begin
                    t_req[i] = 1'b0;
                end
            end
            if ($urandom_range(19, 0) == 0) t_alarm = ~t_alarm;
        end
    endtask

    initial begin
        t_alarm = 1'b0;
        for (int i = 0; i < NI; i++) t_addr[i] = glyph_addr(7'(8'h30 + i), 4'(i));

        // Reset held with every requester active
        t_req = '1;
        drive();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gnt",      32'(bus.gnt),      32'd0);
        chk("reset_rvalid",   32'(bus.rvalid),   32'd0);
        chk("reset_rom_en",   32'(bus.rom_en),   32'd0);
        chk("reset_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("reset_rdata",    32'(bus.rdata),    32'd0);
        reset = 1'b1;
        step();
        chk("first_grant", 32'(bus.gnt), 32'h1);
        t_req = '0;
        run(4, 1'b0);

        // Single request from requester 1
        t_req     = 4'b0010;
        t_addr[1] = glyph_addr(7'h1A, 4'h3);
        step();
        chk("single_rom_addr", 32'(bus.rom_addr), 32'h1A3);
        chk("single_rom_en",   32'(bus.rom_en),   32'h1);
        t_req[1] = 1'b0;
        step();
        step();
        chk("single_rvalid", 32'(bus.rvalid), 32'h2);
        chk("single_rdata",  32'(bus.rdata),  32'(rom_f(11'h1A3)));
        run(2, 1'b0);

        // Storm: all requesters, distinct addresses
        for (int i = 0; i < NI; i++) t_addr[i] = glyph_addr(7'(8'h41 + i), 4'(i + 4));
        t_req = '1;
        run(16, 1'b1);
        t_req = '0;
        run(3, 1'b0);

        // Self-mask: one requester held continuously
        t_req = 4'b0100;
        run(8, 1'b1);
        t_req = '0;
        run(3, 1'b0);

        // Alarm active with all requesters
        t_alarm = 1'b1;
        t_req   = '1;
        run(12, 1'b1);
        t_alarm = 1'b0;
        t_req   = '0;
        run(3, 1'b0);

        // Reset one cycle after a grant: that fetch must never return
        t_req = 4'b0001;
        step();
        chk("mid_grant", 32'(bus.gnt), 32'h1);
        t_req = '0;
        step();
        reset = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("mid_rst_gnt",    32'(bus.gnt),    32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        step();
        t_req = '1;
        step();
        chk("restart_gnt", 32'(bus.gnt), 32'h1);
        t_req = '0;
        run(4, 1'b0);

        // Random requesters, alarm toggling
        run_rand(400);
        t_req   = '0;
        t_alarm = 1'b0;
        run(4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
